// File: rtl/led_status_pkg.sv
// Shared mode constants and activity-FSM state encoding for the LED status driver.
// Definitions only: no logic, no latency, no flow control.
package led_status_pkg;

    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_ON    = 2'd1;
    localparam logic [1:0] LED_BLINK = 2'd2;
    localparam logic [1:0] LED_ACT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } act_state_e;

endpackage

// File: rtl/led_act_stretch.sv
// Per-channel activity stretcher: optional 2-flop sync + edge detect, then ON/GAP stretch FSM.
// State updates one cycle after the event (plus 2 with sync); it accepts events every cycle and never stalls.
module led_act_stretch
    import led_status_pkg::*;
#(
    parameter int STRETCH  = 4,
    parameter int SYNC_ACT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act_i,
    input  logic en_i,
    input  logic tick_i,
    output logic on_o,
    output logic busy_o
);

    localparam int STRETCH_W = $clog2(STRETCH + 1);
    localparam logic [STRETCH_W-1:0] STRETCH_CNT = STRETCH_W'(STRETCH);
    localparam logic [STRETCH_W-1:0] CNT_ONE     = STRETCH_W'(1);

    logic                 ev;
    act_state_e           state_q;
    logic [STRETCH_W-1:0] count_q;
    logic                 pending_q;

    generate
        if (SYNC_ACT != 0) begin : g_sync
            // [1:0] is the synchroniser, [2] holds the previous synchronised level for edge detect.
            logic [2:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_q <= '0;
                else        sync_q <= {sync_q[1:0], act_i};
            end
            assign ev = sync_q[1] & ~sync_q[2];
        end else begin : g_nosync
            assign ev = act_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else if (!en_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev) begin
                        state_q <= ST_ON;
                        count_q <= STRETCH_CNT;
                    end
                end
                ST_ON: begin
                    if (ev) pending_q <= 1'b1;
                    if (tick_i) begin
                        if (count_q == CNT_ONE) begin
                            state_q <= ST_GAP;
                            count_q <= STRETCH_CNT;
                        end else begin
                            count_q <= count_q - CNT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (ev) pending_q <= 1'b1;
                    if (tick_i) begin
                        if (count_q == CNT_ONE) begin
                            // An event landing on the gap-ending tick restarts directly instead of lingering as pending.
                            if (pending_q || ev) begin
                                state_q   <= ST_ON;
                                count_q   <= STRETCH_CNT;
                                pending_q <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                count_q <= '0;
                            end
                        end else begin
                            count_q <= count_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign on_o   = (state_q == ST_ON);
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/led_status_ctrl.sv
// LED/PMOD status driver: shared prescaler, per-channel off/on/blink/activity select and polarity.
// led_o/busy_o are registered, one cycle after the state/prescaler value; outputs only, no backpressure.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                CNT_W      = 24,
    parameter int                TICK_W     = 20,
    parameter int                STRETCH    = 4,
    parameter int                SYNC_ACT   = 1,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW = {NUM_CH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [NUM_CH-1:0]     act_i,
    output logic [NUM_CH-1:0]     led_o,
    output logic [NUM_CH-1:0]     busy_o
);

    logic [CNT_W-1:0]  presc_q;
    logic              tick;
    logic [NUM_CH-1:0] act_on;
    logic [NUM_CH-1:0] act_busy;
    logic [NUM_CH-1:0] lit_d;
    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_q + CNT_W'(1);
    end

    assign tick = &presc_q[TICK_W-1:0];

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            led_act_stretch #(
                .STRETCH  (STRETCH),
                .SYNC_ACT (SYNC_ACT)
            ) u_act (
                .clk    (clk),
                .rst_n  (rst_n),
                .act_i  (act_i[ch]),
                .en_i   (mode_i[2*ch +: 2] == LED_ACT),
                .tick_i (tick),
                .on_o   (act_on[ch]),
                .busy_o (act_busy[ch])
            );
        end
    endgenerate

    // busy is gated by the current mode so leaving activity mode clears it on the same edge as led_o.
    always_comb begin
        lit_d  = '0;
        busy_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (mode_i[2*ch +: 2])
                LED_ON:    lit_d[ch] = 1'b1;
                LED_BLINK: lit_d[ch] = presc_q[CNT_W-1];
                LED_ACT: begin
                    lit_d[ch]  = act_on[ch];
                    busy_d[ch] = act_busy[ch];
                end
                default:   lit_d[ch] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= ACTIVE_LOW;
            busy_q <= '0;
        end else begin
            led_q  <= lit_d ^ ACTIVE_LOW;
            busy_q <= busy_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench: two DUTs (direct events with ACTIVE_LOW=10, synchronised events with ACTIVE_LOW=00)
// share stimulus; an absolute-tick-count reference model queues expected outputs that a negedge monitor compares.
module tb_led_status_ctrl;

    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int TW  = 2;
    localparam int S   = 2;
    localparam logic [1:0] AL0 = 2'b10;
    localparam logic [1:0] AL1 = 2'b00;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] mode_i = 4'b0000;
    logic [1:0] act_i  = 2'b00;
    logic [1:0] led0, busy0, led1, busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_status_ctrl #(
        .NUM_CH(NCH), .CNT_W(CW), .TICK_W(TW), .STRETCH(S), .SYNC_ACT(0), .ACTIVE_LOW(AL0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .act_i(act_i), .led_o(led0), .busy_o(busy0)
    );

    led_status_ctrl #(
        .NUM_CH(NCH), .CNT_W(CW), .TICK_W(TW), .STRETCH(S), .SYNC_ACT(1), .ACTIVE_LOW(AL1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .act_i(act_i), .led_o(led1), .busy_o(busy1)
    );

    // Reference model: activity is described by absolute tick numbers at which ON and GAP end.
    int         m_presc [2];
    int         m_ticks [2];
    bit         m_act   [2][2];
    int         m_on_end[2][2];
    int         m_gap_end[2][2];
    bit         m_pend  [2][2];
    logic [1:0] ah[3];             // act_i sampled at previous edges: [0]=k-1, [1]=k-2, [2]=k-3
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_presc[d] = 0;
            m_ticks[d] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_act[d][c]     = 1'b0;
                m_pend[d][c]    = 1'b0;
                m_on_end[d][c]  = 0;
                m_gap_end[d][c] = 0;
            end
        end
        for (int i = 0; i < 3; i++) ah[i] = 2'b00;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_step(input int d, input logic [1:0] ev, output logic [3:0] exp_o);
        int         t, tn;
        bit         tk;
        logic [1:0] md;
        logic [1:0] led, busy;
        t  = m_ticks[d];
        tk = ((m_presc[d] % (1 << TW)) == (1 << TW) - 1);
        tn = t + (tk ? 1 : 0);
        led  = 2'b00;
        busy = 2'b00;
        for (int c = 0; c < NCH; c++) begin
            md = mode_i[2*c +: 2];
            case (md)
                2'd0: led[c] = 1'b0;
                2'd1: led[c] = 1'b1;
                2'd2: led[c] = 1'((m_presc[d] >> (CW - 1)) & 1);
                default: led[c] = m_act[d][c] && (t < m_on_end[d][c]);
            endcase
            busy[c] = (md == 2'd3) && m_act[d][c];
            if (md != 2'd3) begin
                m_act[d][c]  = 1'b0;
                m_pend[d][c] = 1'b0;
            end else if (!m_act[d][c]) begin
                if (ev[c]) begin
                    m_act[d][c]     = 1'b1;
                    m_on_end[d][c]  = tn + S;
                    m_gap_end[d][c] = tn + 2*S;
                end
            end else begin
                if (ev[c]) m_pend[d][c] = 1'b1;
                if (tn >= m_gap_end[d][c]) begin
                    if (m_pend[d][c]) begin
                        m_on_end[d][c]  = tn + S;
                        m_gap_end[d][c] = tn + 2*S;
                        m_pend[d][c]    = 1'b0;
                    end else begin
                        m_act[d][c] = 1'b0;
                    end
                end
            end
        end
        m_presc[d] = (m_presc[d] + 1) % (1 << CW);
        m_ticks[d] = tn;
        exp_o = {led ^ (d == 0 ? AL0 : AL1), busy};
    endtask

    // Model/expectation producer: one expected entry per DUT per clock edge.
    initial begin
        logic [3:0] e;
        logic [1:0] ev_s;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                ev_s  = ah[1] & ~ah[2];
                ah[2] = ah[1];
                ah[1] = ah[0];
                ah[0] = act_i;
                model_step(0, act_i, e);
                exp_q0.push_back(e);
                model_step(1, ev_s, e);
                exp_q1.push_back(e);
            end
        end
    end

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare away from the rising edge.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_led0", led0, AL0);
                check("reset_busy0", busy0, 2'b00);
                check("reset_led1", led1, AL1);
                check("reset_busy1", busy1, 2'b00);
            end else begin
                if (exp_q0.size() > 0) begin
                    e = exp_q0.pop_front();
                    check("led0", led0, e[3:2]);
                    check("busy0", busy0, e[1:0]);
                end
                if (exp_q1.size() > 0) begin
                    e = exp_q1.pop_front();
                    check("led1", led1, e[3:2]);
                    check("busy1", busy1, e[1:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_presc(input int v);
        for (int i = 0; i < 40 && m_presc[0] != v; i++) @(negedge clk);
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        mode_i = 4'b0101;
        step(4);
        mode_i = 4'b0010;
        step(40);

        // single pulse, then pulse plus a second one during ON
        mode_i = 4'b1111;
        wait_presc(0);
        act_i = 2'b01; step(1); act_i = 2'b00;
        step(40);
        wait_presc(0);
        act_i = 2'b01; step(1); act_i = 2'b00;
        wait_presc(5);
        act_i = 2'b01; step(1); act_i = 2'b00;
        step(60);

        // leave activity mode while ON, then return without an event
        wait_presc(0);
        act_i = 2'b01; step(1); act_i = 2'b00;
        step(3);
        mode_i = 4'b1100;
        step(3);
        mode_i = 4'b1111;
        step(40);

        // held level on ch1
        act_i = 2'b10; step(20); act_i = 2'b00;
        step(60);

        // randomised modes and activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) mode_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) mode_i = 4'b1111;
            act_i[0] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) act_i[1] = ~act_i[1];
            step(1);
        end

        // async reset in the middle of an ON period
        act_i = 2'b00; mode_i = 4'b1111;
        step(4);
        act_i = 2'b11; step(1); act_i = 2'b00;
        step(6);
        #2 rst_n = 1'b0;
        #1;
        check("async_led0", led0, AL0);
        check("async_busy0", busy0, 2'b00);
        check("async_led1", led1, AL1);
        check("async_busy1", busy1, 2'b00);
        step(3);
        rst_n = 1'b1;
        step(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
